// File: rtl/ddr_port_arbiter_if.sv
// Requester-side and AXI4 bridge-side signal bundle for ddr_port_arbiter.
`timescale 1ns/1ps
interface ddr_port_arbiter_if #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned AW   = 30,
    parameter int unsigned DW   = 256
);
    // Requester side, packed per requester
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_we;
    logic [NREQ*AW-1:0]     req_addr;
    logic [NREQ*8-1:0]      req_len;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*DW-1:0]     req_wdata;
    logic [NREQ*DW/8-1:0]   req_wstrb;
    logic [NREQ-1:0]        req_wvalid;
    logic [NREQ-1:0]        req_wready;
    logic [DW-1:0]          req_rdata;
    logic [NREQ-1:0]        req_rvalid;
    logic [NREQ-1:0]        req_done;

    // Bridge side
    logic [AW-1:0]          m_axi_awaddr;
    logic [7:0]             m_axi_awlen;
    logic                   m_axi_awvalid;
    logic                   m_axi_awready;
    logic [DW-1:0]          m_axi_wdata;
    logic [DW/8-1:0]        m_axi_wstrb;
    logic                   m_axi_wlast;
    logic                   m_axi_wvalid;
    logic                   m_axi_wready;
    logic                   m_axi_bready;
    logic [AW-1:0]          m_axi_araddr;
    logic [7:0]             m_axi_arlen;
    logic                   m_axi_arvalid;
    logic                   m_axi_arready;
    logic [DW-1:0]          m_axi_rdata;
    logic                   m_axi_rvalid;
    logic                   m_axi_rready;

    // Arbiter view: serves the requesters and masters the bridge
    modport master (
        input  req_valid, req_we, req_addr, req_len, req_wdata, req_wstrb, req_wvalid,
        output req_ready, req_wready, req_rdata, req_rvalid, req_done,
        output m_axi_awaddr, m_axi_awlen, m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        input  m_axi_wready,
        output m_axi_bready,
        output m_axi_araddr, m_axi_arlen, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rdata, m_axi_rvalid,
        output m_axi_rready
    );

    // Environment view: requesters plus the bridge
    modport slave (
        output req_valid, req_we, req_addr, req_len, req_wdata, req_wstrb, req_wvalid,
        input  req_ready, req_wready, req_rdata, req_rvalid, req_done,
        input  m_axi_awaddr, m_axi_awlen, m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        output m_axi_wready,
        input  m_axi_bready,
        input  m_axi_araddr, m_axi_arlen, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rdata, m_axi_rvalid,
        input  m_axi_rready
    );
endinterface

// File: rtl/ddr_port_arbiter.sv
// Round-robin arbiter sharing the MIG bridge AXI4 slave port between NREQ requesters.
// One transaction in flight; beats are counted locally since bresp/rlast are unusable.
`timescale 1ns/1ps
module ddr_port_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned AW   = 30,
    parameter int unsigned DW   = 256
) (
    input  logic               clk,
    input  logic               aresetn,
    ddr_port_arbiter_if.master bus,
    output logic               busy
);
    localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {StIdle, StAaddr, StWdata, StRaddr, StRdata} state_e;

    state_e          state_q;
    logic [GW-1:0]   rr_ptr_q;
    logic [GW-1:0]   gnt_q;
    logic [AW-1:0]   addr_q;
    logic [7:0]      len_q;
    logic [8:0]      beat_cnt_q;
    logic            awvalid_q;
    logic            arvalid_q;
    logic            rready_q;
    logic [NREQ-1:0] ready_q;
    logic [NREQ-1:0] done_q;

    logic            pick_found;
    logic [GW-1:0]   pick_idx;
    logic            pick_we;
    logic [AW-1:0]   pick_addr;
    logic [7:0]      pick_len;
    logic [DW-1:0]   sel_wdata;
    logic [DW/8-1:0] sel_wstrb;
    logic            sel_wvalid;
    logic [NREQ-1:0] gnt_oh;
    logic [GW-1:0]   gnt_next;
    logic            last_beat;
    logic            w_hs;

    // Scan twice around the ring so the first hit at or above rr_ptr wins, wrapping to 0.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < 2 * NREQ; k++) begin
            if (!pick_found && k >= int'(rr_ptr_q) && bus.req_valid[k % NREQ]) begin
                pick_found = 1'b1;
                pick_idx   = GW'(k % NREQ);
            end
        end
        pick_we   = 1'b0;
        pick_addr = '0;
        pick_len  = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (pick_idx == GW'(j)) begin
                pick_we   = bus.req_we[j];
                pick_addr = bus.req_addr[j*AW +: AW];
                pick_len  = bus.req_len[j*8 +: 8];
            end
        end
    end

    always_comb begin
        sel_wdata  = '0;
        sel_wstrb  = '0;
        sel_wvalid = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (gnt_q == GW'(j)) begin
                sel_wdata  = bus.req_wdata[j*DW +: DW];
                sel_wstrb  = bus.req_wstrb[j*(DW/8) +: DW/8];
                sel_wvalid = bus.req_wvalid[j];
            end
        end
    end

    assign gnt_oh    = NREQ'(1) << gnt_q;
    assign gnt_next  = (gnt_q == GW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
    // 9-bit counter against zero-extended len: len=255 completes at count 255, no wrap
    assign last_beat = (beat_cnt_q == {1'b0, len_q});
    assign w_hs      = (state_q == StWdata) && sel_wvalid && bus.m_axi_wready;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            gnt_q      <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            beat_cnt_q <= '0;
            awvalid_q  <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            ready_q    <= '0;
            done_q     <= '0;
        end else begin
            ready_q <= '0;
            done_q  <= '0;
            case (state_q)
                StIdle: begin
                    if (pick_found) begin
                        gnt_q      <= pick_idx;
                        addr_q     <= pick_addr;
                        len_q      <= pick_len;
                        beat_cnt_q <= '0;
                        if (pick_we) begin
                            state_q   <= StAaddr;
                            awvalid_q <= 1'b1;
                        end else begin
                            state_q   <= StRaddr;
                            arvalid_q <= 1'b1;
                            rready_q  <= 1'b1;
                        end
                    end
                end
                StAaddr: begin
                    if (bus.m_axi_awready) begin
                        awvalid_q <= 1'b0;
                        ready_q   <= gnt_oh;
                        state_q   <= StWdata;
                    end
                end
                StWdata: begin
                    if (w_hs) begin
                        if (last_beat) begin
                            done_q     <= gnt_oh;
                            state_q    <= StIdle;
                            rr_ptr_q   <= gnt_next;
                            beat_cnt_q <= '0;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 9'd1;
                        end
                    end
                end
                StRaddr: begin
                    if (bus.m_axi_arready) begin
                        arvalid_q <= 1'b0;
                        ready_q   <= gnt_oh;
                        state_q   <= StRdata;
                    end
                end
                StRdata: begin
                    if (bus.m_axi_rvalid) begin
                        if (last_beat) begin
                            done_q     <= gnt_oh;
                            state_q    <= StIdle;
                            rr_ptr_q   <= gnt_next;
                            beat_cnt_q <= '0;
                            rready_q   <= 1'b0;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 9'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.m_axi_awaddr  = addr_q;
    assign bus.m_axi_awlen   = len_q;
    assign bus.m_axi_awvalid = awvalid_q;
    assign bus.m_axi_araddr  = addr_q;
    assign bus.m_axi_arlen   = len_q;
    assign bus.m_axi_arvalid = arvalid_q;
    assign bus.m_axi_wdata   = sel_wdata;
    assign bus.m_axi_wstrb   = sel_wstrb;
    assign bus.m_axi_wvalid  = (state_q == StWdata) && sel_wvalid;
    assign bus.m_axi_wlast   = (state_q == StWdata) && last_beat;
    assign bus.m_axi_bready  = 1'b1;
    assign bus.m_axi_rready  = rready_q;

    assign bus.req_ready  = ready_q;
    assign bus.req_done   = done_q;
    assign bus.req_wready = ((state_q == StWdata) && bus.m_axi_wready) ? gnt_oh : '0;
    // Stray read beats outside RDATA are dropped here
    assign bus.req_rvalid = ((state_q == StRdata) && bus.m_axi_rvalid) ? gnt_oh : '0;
    assign bus.req_rdata  = bus.m_axi_rdata;

    assign busy = (state_q != StIdle);
endmodule

// File: doc/ddr_port_arbiter.md
Name: ddr_port_arbiter

Overview:
- Round-robin arbiter sharing the single AXI4 slave port of the DDR3 MIG bridge between NREQ requesters (e.g. host DMA and accelerator).
- One transaction in flight at a time, read or write, single ID.
- Beats counted locally, since the bridge provides no usable bresp or rlast.
- Sits in the ui_clk domain between the requester blocks and the bridge.

Parameters:
NREQ, 2, number of requesters (2..4)
AW, 30, byte address width
DW, 256, data beat width; strobe width DW/8

Ports:
clk  in  1  bridge ui_clk
aresetn  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester transaction request; held until req_ready
req_we  in  NREQ  1=write, 0=read
req_addr  in  NREQ*AW  packed start byte address
req_len  in  NREQ*8  packed AXI len (beats-1)
req_ready  out  NREQ  one-cycle pulse when the address is accepted by the bridge
req_wdata  in  NREQ*DW  packed write data
req_wstrb  in  NREQ*DW/8  packed write strobes
req_wvalid  in  NREQ  write beat valid
req_wready  out  NREQ  write beat accepted (granted requester only)
req_rdata  out  DW  read data, broadcast
req_rvalid  out  NREQ  read beat valid, granted requester only; no backpressure
req_done  out  NREQ  one-cycle pulse after last beat
busy  out  1  transaction in progress
m_axi_awaddr/awlen/awvalid  out  AW/8/1  write address
m_axi_awready  in  1
m_axi_wdata/wstrb/wlast/wvalid  out  DW/DW/8/1/1  write data
m_axi_wready  in  1
m_axi_bready  out  1  tied 1
m_axi_araddr/arlen/arvalid  out  AW/8/1  read address
m_axi_arready  in  1
m_axi_rdata  in  DW
m_axi_rvalid  in  1
m_axi_rready  out  1

Behaviour:
- Reset values:
  - state=IDLE, rr_ptr=0, beat_cnt=0.
  - All valid, ready and done outputs 0; awaddr/araddr/len regs 0.
  - busy=0; m_axi_rready=0; m_axi_bready=1.
- States:
  - IDLE: pick the first asserted req_valid scanning from rr_ptr upward (mod NREQ).
    - Latch gnt index, we, addr, len.
    - Go to AADDR if write, RADDR if read.
    - No request: stay.
  - AADDR: awvalid=1 from the latched regs.
    - On awvalid&&awready: pulse req_ready[gnt], go to WDATA.
  - WDATA:
    - m_axi_wvalid=req_wvalid[gnt]; wdata/wstrb muxed from gnt.
    - req_wready[gnt]=m_axi_wready.
    - wlast=(beat_cnt==len).
    - Each wvalid&&wready: beat_cnt++.
    - On the last beat: pulse req_done[gnt], go to IDLE.
  - RADDR:
    - arvalid=1 and m_axi_rready=1 (the bridge gates arready on rready).
    - On arvalid&&arready: pulse req_ready[gnt], go to RDATA.
  - RDATA:
    - m_axi_rready=1.
    - req_rvalid[gnt]=m_axi_rvalid; req_rdata=m_axi_rdata.
    - Each rvalid: beat_cnt++.
    - On beat len: pulse req_done[gnt], go to IDLE.
- On every return to IDLE: rr_ptr=(gnt+1) mod NREQ; beat_cnt=0.
- Latency: req_valid seen in IDLE at cycle t -> aw/arvalid asserted at t+1, registered. Minimum of 2 cycles between back-to-back transactions (done cycle, then IDLE).
- beat_cnt is 9 bits; len=255 gives 256 beats, with no wrap before compare.
- Simultaneous requests: rr_ptr decides. A non-granted requester waits; its req_ready stays 0.
- Requests arriving while busy are not sampled until IDLE.
- Changing req_addr/len after grant has no effect (latched).
- Requester must hold req_valid until req_ready; dropping it early is a protocol violation and the latched transaction still completes.
- A read beat with rvalid arriving outside RDATA is ignored; no req_rvalid.
- aresetn low mid-transaction: immediate return to reset values and all valids drop. The bridge is reset by the same aresetn.
- busy=1 in every state except IDLE.

Test Plan:
1. Req0 write, addr=0x100, len=3 → 1 awvalid handshake with awaddr=0x100, awlen=3. 4 W beats with wlast on the 4th, req_done[0] on the cycle after the last beat, rr_ptr=1.
2. Req1 read, addr=0x2000, len=0, rvalid 1 beat → arlen=0, req_rvalid[1] 1 cycle with matching data, req_rvalid[0] stays 0, req_done[1] pulse.
3. Both valid at the same cycle, repeated 4 times with rr_ptr=0 → grant order 0,1,0,1 with no starvation.
4. Write len=255 with wvalid throttled every other cycle → exactly 256 beats, wlast only on beat 256, busy cleared afterwards.
5. aresetn low during WDATA at beat 2 of 8 → all outputs at reset values the same cycle, state IDLE. After release a new req0 read is granted normally.
6. Req0 changes req_addr after req_ready → the next transaction uses the new value; the in-flight transaction keeps the latched address.
